alu_seq_nbit: RTL and testbench
===============================

// Module: alu_seq_nbit
// PURPOSE
//  Parametrised N-bit ALU built from 4-bit carry-lookahead groups, wrapped in a
//  valid/ready handshake with a registered result and flags. Single-cycle ops
//  (AND/OR/ADD/SUB/SLT) and an optional multi-cycle shift-add multiply. Sits
//  between the decode stage and writeback of the datapath.
// PARAMETERS
//  WIDTH      32  operand/result width; must be a multiple of CLA_GROUP, >= 8
//  CLA_GROUP   4  bits per lookahead group; generate/propagate rippled between groups
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   3      000 AND, 001 OR, 010 ADD, 011 MUL, 110 SUB, 111 SLT
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  cout       out  1      carry out of MSB (ADD/SUB); MUL: upper product half != 0
//  zero       out  1      result == 0
//  overflow   out  1      signed overflow (ADD/SUB only)
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, result=0, cout=0, zero=0, overflow=0;
//    in_ready goes 1 the cycle after reset deasserts.
//  - FSM: IDLE (accepts), MUL (iterating). in_ready = (state==IDLE) &&
//    (!out_valid || out_ready). Accept = in_valid && in_ready; a/b/op sampled
//    only at accept, ignored otherwise.
//  - Single-cycle op: result/flags registered on accept edge; out_valid=1 next
//    cycle (latency 1). Back-to-back accepts with out_ready=1 give 1 result/cycle.
//  - MUL: IDLE->MUL on accept; WIDTH cycles of shift-add; on last cycle load
//    result, out_valid=1, ->IDLE (latency WIDTH+1). in_ready=0 throughout MUL.
//  - Output hold: while out_valid && !out_ready, result and flags stable.
//    out_valid clears on out_ready unless a new accept occurs same edge.
//  - ADD: a+b; cout = carry out of bit WIDTH-1; overflow = signed overflow.
//  - SUB: a+~b+1 (cin=1); cout=1 means no borrow (a>=b unsigned).
//  - SLT: result = {0..0, sum[MSB] ^ overflow} of a-b (correct at signed
//    overflow); cout=overflow=0.
//  - AND/OR: bitwise; cout=overflow=0.
//  - MUL: result = low WIDTH bits of unsigned a*b; overflow=0.
//  - Ops 100/101: result=0, zero=1, cout=overflow=0; accepted at latency 1.
//  - zero derived from the registered result value for every op.
//  - Reset mid-MUL: partial product discarded, no output produced.
// CONFIGURATION
//  ALU_MUL_EN defined: op 011 runs the multi-cycle multiplier as above.
//  ALU_MUL_EN undefined: no multiplier/MUL state; op 011 treated as 100/101
//    (result=0, zero=1, latency 1); in_ready = !out_valid || out_ready.
// TESTING (WIDTH=32)
//  ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> 1 cycle: result=0, zero=1, cout=1, overflow=0
//  ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, cout=0; SUB 5-7 -> 0xFFFFFFFE, cout=0
//  SLT a=0x80000000, b=0x00000001 -> result=1; SLT a=1, b=0x80000000 -> result=0
//  MUL 0x00010000*0x00010000 (ALU_MUL_EN) -> out_valid after 33 cycles, result=0,
//    cout=1; in_ready=0 throughout
//  out_ready=0 for 5 cycles after AND 0xF0F0F0F0&0xFF00FF00 -> result 0xF000F000 held,
//    in_ready=0 until out_ready=1
//  reset pulse at MUL cycle 10 -> out_valid=0, result=0, in_ready=1 cycle after
//    reset drops; next ADD 2+3 -> 5

Source files
------------

// File: rtl/alu_seq_nbit.sv
// N-bit ALU on 4-bit carry-lookahead groups behind a valid/ready handshake.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for op 011.
module alu_seq_nbit #(
  parameter int WIDTH     = 32,
  parameter int CLA_GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int NG = WIDTH / CLA_GROUP;

  // Full lookahead inside a group: every carry is a flat function of g/p/cin.
  function automatic logic [CLA_GROUP:0] cla_carry(input logic [CLA_GROUP-1:0] g,
                                                   input logic [CLA_GROUP-1:0] p,
                                                   input logic cin);
    logic [CLA_GROUP:0] c;
    logic term;
    logic pp;
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < CLA_GROUP; j++) begin
      term = g[j];
      pp   = p[j];
      for (int k = j - 1; k >= 0; k--) begin
        term = term | (pp & g[k]);
        pp   = pp & p[k];
      end
      c[j+1] = term | (pp & cin);
    end
    return c;
  endfunction

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [NG:0]      grp_carry;
  logic             add_ovf;

  assign is_sub       = op[2];
  assign b_eff        = is_sub ? ~b : b;
  assign grp_carry[0] = is_sub;

  genvar gi;
  for (gi = 0; gi < NG; gi++) begin : g_cla
    logic [CLA_GROUP-1:0] ga, gb, gg, gp;
    logic [CLA_GROUP:0]   gcarry;
    assign ga     = a[gi*CLA_GROUP +: CLA_GROUP];
    assign gb     = b_eff[gi*CLA_GROUP +: CLA_GROUP];
    assign gg     = ga & gb;
    assign gp     = ga ^ gb;
    assign gcarry = cla_carry(gg, gp, grp_carry[gi]);
    assign sum[gi*CLA_GROUP +: CLA_GROUP] = gp ^ gcarry[CLA_GROUP-1:0];
    assign grp_carry[gi+1] = gcarry[CLA_GROUP];
  end

  assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_ovf;

  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    case (op)
      3'b000: alu_result = a & b;
      3'b001: alu_result = a | b;
      3'b010, 3'b110: begin
        alu_result = sum;
        alu_cout   = grp_carry[NG];
        alu_ovf    = add_ovf;
      end
      3'b111: alu_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: alu_result = '0;
    endcase
  end

  logic             accept;
  logic             is_mul_op;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             zero_reg;
  logic             overflow_reg;

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mul_a_reg, mul_hi_reg, mul_lo_reg;
  logic [WIDTH:0]   mul_step;
  logic             mul_done;

  assign is_mul_op = (op == 3'b011);
  // One extra MUL cycle after the WIDTH iterations moves the product out.
  assign mul_done  = (state_reg == S_MUL) && (cnt_reg == CW'(WIDTH));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && is_mul_op) state_next = S_MUL;
      S_MUL:   if (mul_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = !reset && (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
  end

  assign mul_step = {1'b0, mul_hi_reg} + (mul_lo_reg[0] ? {1'b0, mul_a_reg} : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      mul_a_reg  <= '0;
      mul_hi_reg <= '0;
      mul_lo_reg <= '0;
    end else if (accept && is_mul_op) begin
      cnt_reg    <= '0;
      mul_a_reg  <= a;
      mul_hi_reg <= '0;
      mul_lo_reg <= b;
    end else if (state_reg == S_MUL && !mul_done) begin
      cnt_reg    <= cnt_reg + 1'b1;
      mul_hi_reg <= mul_step[WIDTH:1];
      mul_lo_reg <= {mul_step[0], mul_lo_reg[WIDTH-1:1]};
    end
  end
`else
  assign is_mul_op = 1'b0;
  assign in_ready  = !reset && (!out_valid_reg || out_ready);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (accept && !is_mul_op) begin
      out_valid_reg <= 1'b1;
      result_reg    <= alu_result;
      cout_reg      <= alu_cout;
      zero_reg      <= (alu_result == '0);
      overflow_reg  <= alu_ovf;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      out_valid_reg <= 1'b1;
      result_reg    <= mul_lo_reg;
      cout_reg      <= |mul_hi_reg;
      zero_reg      <= (mul_lo_reg == '0);
      overflow_reg  <= 1'b0;
    end
`endif
    else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign cout      = cout_reg;
  assign zero      = zero_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Scoreboard bench for alu_seq_nbit at WIDTH=32: directed vectors, monitor pops on handshake.
module tb_alu_seq_nbit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        zero;
  logic        overflow;

  alu_seq_nbit #(.WIDTH(32), .CLA_GROUP(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        v;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops and compares on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: result=%h with no pending transaction", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.r || cout !== e.c || zero !== e.z || overflow !== e.v) begin
          failures++;
          $display("FAIL result_flags: got r=%h c=%b z=%b v=%b, want r=%h c=%b z=%b v=%b",
                   result, cout, zero, overflow, e.r, e.c, e.z, e.v);
        end else begin
          $display("txn ok: r=%h c=%b z=%b v=%b", result, cout, zero, overflow);
        end
        if (e.lat > 0) begin
          checks++;
          if (cyc - e.acc != e.lat) begin
            failures++;
            $display("FAIL latency: got %0d cycles, want %0d", cyc - e.acc, e.lat);
          end
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 right after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] er, input logic ec, input logic ez, input logic ev,
                       input int lat);
    exp_t e;
    bit   got;
    got      = 1'b0;
    in_valid = 1'b1;
    op       = o;
    a        = aa;
    b        = bb;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got   = 1'b1;
        e.r   = er;
        e.c   = ec;
        e.z   = ez;
        e.v   = ev;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
      end
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%b, want 1 within 100 cycles", in_ready);
    end
  endtask

  task automatic drain(input int budget);
    for (int t = 0; t < budget && sb.size() != 0; t++) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d outstanding, want 0", sb.size());
    end
  endtask

  task automatic check_mul_busy();
    bit bad;
    bit seen;
    bad  = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else if (in_ready) bad = 1'b1;
    end
    checks++;
    if (bad || !seen) begin
      failures++;
      $display("FAIL mul_busy: in_ready_seen=%b out_valid_seen=%b, want 0 and 1", bad, seen);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || cout !== 1'b0 || zero !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: v=%b r=%h c=%b z=%b o=%b, want all 0", out_valid, result, cout, zero, overflow);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk);
    #2;

    // Back-to-back single-cycle ops, each at latency 1.
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1);
    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1);
    issue(3'b110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1);
    issue(3'b110, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1);
    issue(3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1);
    issue(3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1);
    issue(3'b111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1);
    issue(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1);
    issue(3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1);
    issue(3'b100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1);
    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1);
    issue(3'b010, 32'h0000_0003, 32'h0000_0005, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1);
    drain(20);

`ifdef ALU_MUL_EN
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 33);
    check_mul_busy();
    drain(20);
    issue(3'b011, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 33);
    check_mul_busy();
    drain(20);
    issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 33);
    check_mul_busy();
    drain(20);
`else
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1);
    drain(20);
`endif

    // Output hold under back-pressure.
    out_ready = 1'b0;
    issue(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'hF000_F000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: v=%b r=%h rdy=%b, want 1 f000f000 0", t, out_valid, result, in_ready);
      end
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain(10);

    // Reset while a transaction is in flight discards it.
`ifdef ALU_MUL_EN
    issue(3'b011, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 33);
    repeat (9) @(posedge clk);
    #2;
`else
    out_ready = 1'b0;
    issue(3'b010, 32'h0000_0003, 32'h0000_0005, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1);
`endif
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: v=%b r=%h, want 0 00000000", out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_mid_reset: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk);
    #2;
    issue(3'b010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1);
    drain(10);
    repeat (40) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
